// File: rtl/pipelined_rca_pkg.sv
// Shared types and the full-adder cell for the pipelined ripple-carry adder.
// Default geometry matches the 16-bit, 4-segment configuration used in datapaths.
package pipelined_rca_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  typedef struct packed {
    logic s;
    logic co;
  } fa_t;

  // One-bit full adder; the ripple chain in each segment is built from this cell.
  function automatic fa_t full_add(input logic x, input logic y, input logic ci);
    fa_t r;
    r.s  = x ^ y ^ ci;
    r.co = (x & y) | (ci & (x ^ y));
    return r;
  endfunction

endpackage

// File: rtl/pipelined_rca_if.sv
// Valid/ready operand and result channels of the pipelined adder.
// master drives operands and result backpressure; slave is the adder.
interface pipelined_rca_if
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipelined_rca_segment.sv
// Purely combinational SEG-bit ripple-carry segment built from the full-adder cell.
// Also exposes the carry into its MSB so the top segment can derive signed overflow.
module rca_segment
  import pipelined_rca_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cm
);

  logic carry;
  fa_t  fa;

  // NOTE: blocking assignments here model the ripple as ordered combinational steps;
  // every output gets a default first so no latch can be inferred.
  always_comb begin
    carry = ci;
    cm    = ci;
    s     = '0;
    fa    = '0;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) cm = carry;
      fa    = full_add(a[i], b[i], carry);
      s[i]  = fa.s;
      carry = fa.co;
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_rca.sv
// WIDTH-bit add/subtract split into STAGES ripple segments with registered carries,
// skewed operands, deskewed sums and valid/ready flow control on both sides.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic           clk,
  input logic           rst_n,
  pipelined_rca_if.slave bus
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_rca: WIDTH must be a non-zero multiple of STAGES");
  end

  // Rank k holds a beat that has completed segments 0..k-1.
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  opa [STAGES];
  logic [WIDTH-1:0]  opb [STAGES];
  logic [WIDTH-1:0]  acc [STAGES];
  logic              cy  [STAGES];

  logic [SEG-1:0]    seg_sum [STAGES];
  logic              seg_co  [STAGES];
  logic              seg_cm  [STAGES];

  logic              out_vld;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              stall;
  logic              advance;

  assign stall         = out_vld & ~bus.out_ready;
  assign advance       = ~stall;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_vld;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    rca_segment #(.SEG(SEG)) u_seg (
      .a  (opa[k][k*SEG +: SEG]),
      .b  (opb[k][k*SEG +: SEG]),
      .ci (cy[k]),
      .s  (seg_sum[k]),
      .co (seg_co[k]),
      .cm (seg_cm[k])
    );
  end

  // Control and the visible result are reset; a reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld     <= '0;
      out_vld <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (advance) begin
      vld[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) vld[k] <= vld[k-1];
      out_vld <= vld[STAGES-1];
      sum_q   <= acc[STAGES-1];
      sum_q[(STAGES-1)*SEG +: SEG] <= seg_sum[STAGES-1];
      cout_q  <= seg_co[STAGES-1];
      ovf_q   <= seg_co[STAGES-1] ^ seg_cm[STAGES-1];
    end
  end

  // NOTE: the internal datapath ranks carry no reset; their contents only matter
  // when the matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      opa[0] <= bus.a;
      opb[0] <= bus.sub ? ~bus.b : bus.b;
      cy[0]  <= bus.cin ^ bus.sub;
      acc[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        opa[k] <= opa[k-1];
        opb[k] <= opb[k-1];
        cy[k]  <= seg_co[k-1];
        acc[k] <= acc[k-1];
        acc[k][(k-1)*SEG +: SEG] <= seg_sum[k-1];
      end
    end
  end

endmodule
